// File: rtl/prog_loader.sv
// prog_loader
//   Program-memory writer on the producer side of the instruction fetch path.
//   It accepts a framed byte stream: SYNC_BYTE, a 12-bit length (high nibble
//   byte, then low byte), the payload, and one checksum byte. Payload bytes
//   are written sequentially from address 0. The CPU stays held in reset
//   while loading and is released only after the checksum verifies.
//
// Ports
//   clk            system clock
//   arst_n         synchronous active-low reset (sampled on posedge clk)
//   start          single-cycle pulse; begins a load from IDLE/DONE/ERROR
//   in_valid       stream byte valid
//   in_data        stream byte
//   in_ready       loader accepts a byte this cycle
//   pm_we          program memory write enable (one cycle per payload byte)
//   pm_addr        program memory write address
//   pm_wdata       program memory write data
//   bootstrapping  high while a load is in progress
//   cpu_rst_n      active-low CPU hold; high only after a verified load
//   busy           high in any state other than IDLE, DONE or ERROR
//   done           sticky; load verified
//   error          sticky; load failed
//   err_code       01 length, 10 checksum, 11 timeout, 00 none

module prog_loader #(
  parameter int         ADDR_W    = 12,
  parameter int         MAX_LEN   = 4096,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [7:0]        pm_wdata,
  output logic              bootstrapping,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  // The idle counter only needs to reach TIMEOUT-1; the cycle after that
  // is the one that trips the abort.
  localparam int                TMO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       MAX_LEN_U = MAX_LEN;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_SUM = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t           state;
  logic [11:0]      len;
  logic [11:0]      idx;
  logic [7:0]       checksum;
  logic [TMO_W-1:0] tmo_cnt;

  logic        accept;
  logic [11:0] len_next;
  logic [7:0]  final_sum;

  assign accept    = in_valid && in_ready;
  assign len_next  = {len[11:8], in_data};
  assign final_sum = checksum + in_data;

  // Single FSM register block. Every output is registered and updated on the
  // same edge as the state change, so in_ready/busy/bootstrapping always
  // match the state they decode. An accepted byte always beats the timeout.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      pm_we         <= 1'b0;
      pm_addr       <= '0;
      pm_wdata      <= '0;
      bootstrapping <= 1'b0;
      cpu_rst_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'b00;
      len           <= '0;
      idx           <= '0;
      checksum      <= '0;
      tmo_cnt       <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state         <= SYNC;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            bootstrapping <= 1'b1;
            cpu_rst_n     <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'b00;
            idx           <= '0;
            checksum      <= '0;
            tmo_cnt       <= '0;
          end
        end
        default: begin
          if (accept) begin
            tmo_cnt <= '0;
            case (state)
              SYNC: begin
                if (in_data == SYNC_BYTE) begin
                  state <= LEN_HI;
                end
              end
              LEN_HI: begin
                len[11:8] <= in_data[3:0];
                state     <= LEN_LO;
              end
              LEN_LO: begin
                len[7:0] <= in_data;
                if ({20'd0, len_next} > MAX_LEN_U) begin
                  state         <= ERROR;
                  in_ready      <= 1'b0;
                  busy          <= 1'b0;
                  bootstrapping <= 1'b0;
                  error         <= 1'b1;
                  err_code      <= ERR_LEN;
                end else if (len_next == 12'd0) begin
                  state <= CHECK;
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                pm_we    <= 1'b1;
                pm_addr  <= ADDR_W'(idx);
                pm_wdata <= in_data;
                checksum <= checksum + in_data;
                idx      <= idx + 12'd1;
                if (idx == len - 12'd1) begin
                  state <= CHECK;
                end
              end
              CHECK: begin
                in_ready      <= 1'b0;
                busy          <= 1'b0;
                bootstrapping <= 1'b0;
                if (final_sum == 8'h00) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
                end else begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  err_code <= ERR_SUM;
                end
              end
              default: ;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= ERROR;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            bootstrapping <= 1'b0;
            error         <= 1'b1;
            err_code      <= ERR_TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Bench for prog_loader. Frames are built in the bench, a frame-level
//   reference model predicts the write list and final status, and a monitor
//   compares every pm_we pulse with the predicted writes. A second instance
//   with a small MAX_LEN covers the length limit.

module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  localparam int MAIN_MAX = 4096;

  logic        clk      = 1'b0;
  logic        arst_n   = 1'b0;
  logic        start    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;

  logic        in_ready, pm_we, bootstrapping, cpu_rst_n, busy, done, error;
  logic [11:0] pm_addr;
  logic [7:0]  pm_wdata;
  logic [1:0]  err_code;

  logic        s_in_ready, s_pm_we, s_bootstrapping, s_cpu_rst_n, s_busy, s_done, s_error;
  logic [11:0] s_pm_addr;
  logic [7:0]  s_pm_wdata;
  logic [1:0]  s_err_code;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_w;
  logic [11:0] last_we_addr = 12'h000;
  int          small_we_cnt = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(12), .MAX_LEN(MAIN_MAX), .SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .bootstrapping(bootstrapping), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  prog_loader #(.ADDR_W(12), .MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut_small (
    .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .pm_we(s_pm_we), .pm_addr(s_pm_addr), .pm_wdata(s_pm_wdata),
    .bootstrapping(s_bootstrapping), .cpu_rst_n(s_cpu_rst_n), .busy(s_busy), .done(s_done),
    .error(s_error), .err_code(s_err_code)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write the main loader issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      checkOutput("we_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checkOutput("we_addr", 32'(pm_addr), 32'(exp_w[19:8]));
        checkOutput("we_data", 32'(pm_wdata), 32'(exp_w[7:0]));
      end
      last_we_addr = pm_addr;
    end
    if (s_pm_we === 1'b1) small_we_cnt++;
  end

  // Frame-level reference: find the sync byte, read the length, predict the
  // sequential writes and the verdict of the checksum byte.
  task automatic modelFrame(input byte_q_t frame, output logic e_done, output logic e_err,
                            output logic [1:0] e_code);
    int p, len, sum;
    p = 0;
    while (p < frame.size() && frame[p] != 8'hA5) p++;
    len = int'(frame[p+1] & 8'h0F) * 256 + int'(frame[p+2]);
    p += 3;
    e_done = 1'b0;
    e_err  = 1'b0;
    e_code = 2'b00;
    if (len > MAIN_MAX) begin
      e_err  = 1'b1;
      e_code = 2'b01;
      return;
    end
    sum = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({12'(i), frame[p+i]});
      sum += int'(frame[p+i]);
    end
    if ((sum + int'(frame[p+len])) % 256 == 0) begin
      e_done = 1'b1;
    end else begin
      e_err  = 1'b1;
      e_code = 2'b10;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    arst_n   = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outputs",
                32'({in_ready, pm_we, busy, done, error, err_code, bootstrapping, cpu_rst_n}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle edges and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap, input logic with_start);
    int guard;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic runFrame(input string name, input byte_q_t frame, input int start_at);
    logic       e_done, e_err;
    logic [1:0] e_code;
    modelFrame(frame, e_done, e_err, e_code);
    pulseStart();
    checkOutput({name, "_boot_on"}, 32'(bootstrapping), 32'd1);
    checkOutput({name, "_cpu_held"}, 32'(cpu_rst_n), 32'd0);
    checkOutput({name, "_busy_on"}, 32'(busy), 32'd1);
    checkOutput({name, "_flags_clr"}, 32'({done, error, err_code}), 32'd0);
    for (int i = 0; i < frame.size(); i++)
      applyStimulus(frame[i], int'($urandom_range(0, 2)), i == start_at);
    checkOutput({name, "_done"}, 32'(done), 32'(e_done));
    checkOutput({name, "_error"}, 32'(error), 32'(e_err));
    checkOutput({name, "_err_code"}, 32'(err_code), 32'(e_code));
    checkOutput({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_done));
    checkOutput({name, "_boot_off"}, 32'({bootstrapping, busy, in_ready}), 32'd0);
    checkOutput({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    byte_q_t     f;
    logic        e_done, e_err;
    logic [1:0]  e_code;
    int          len, junk, sum;
    logic [7:0]  b;

    applyReset();

    // Nominal load, with a stray start pulse mid-frame that must be ignored.
    f = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    runFrame("nominal", f, 4);

    f = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    runFrame("badsum", f, -1);

    f = {8'hA5, 8'h00, 8'h00, 8'h00};
    runFrame("zerolen", f, -1);

    // Resync over leading junk and the largest length the field can carry.
    f = {8'h00, 8'hFF, 8'hA5, 8'h0F, 8'hFF};
    sum = 0;
    for (int i = 0; i < 4095; i++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      sum += int'(b);
    end
    f.push_back(8'(256 - (sum % 256)));
    runFrame("long", f, -1);
    checkOutput("long_last_addr", 32'(last_we_addr), 32'h0FFE);

    // Timeout: eight idle edges in DATA abort the load.
    pulseStart();
    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'h04, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("tmo_7_no_error", 32'(error), 32'd0);
    checkOutput("tmo_7_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("tmo_error", 32'(error), 32'd1);
    checkOutput("tmo_err_code", 32'(err_code), 32'd3);
    checkOutput("tmo_cpu_held", 32'(cpu_rst_n), 32'd0);
    checkOutput("tmo_idle_outs", 32'({busy, bootstrapping, in_ready, done}), 32'd0);

    // A byte accepted on the eighth idle edge wins over the timeout.
    f = {8'hA5, 8'h00, 8'h02, 8'h3C, 8'h44, 8'h80};
    modelFrame(f, e_done, e_err, e_code);
    pulseStart();
    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'h02, 0, 1'b0);
    applyStimulus(8'h3C, 7, 1'b0);
    checkOutput("tmo_edge_no_error", 32'(error), 32'd0);
    applyStimulus(8'h44, 7, 1'b0);
    applyStimulus(8'h80, 0, 1'b0);
    checkOutput("tmo_edge_done", 32'(done), 32'(e_done));
    checkOutput("tmo_edge_err", 32'(error), 32'(e_err));

    // Length limit on the small instance: 16 is accepted, 17 is rejected.
    applyReset();
    f = {8'hA5, 8'h00, 8'h10};
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      sum += int'(b);
    end
    f.push_back(8'(256 - (sum % 256)));
    runFrame("len16", f, -1);
    checkOutput("small_len16_done", 32'(s_done), 32'd1);

    applyReset();
    small_we_cnt = 0;
    pulseStart();
    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'h11, 0, 1'b0);
    checkOutput("small_len_error", 32'(s_error), 32'd1);
    checkOutput("small_len_code", 32'(s_err_code), 32'd1);
    checkOutput("small_len_flags", 32'({s_done, s_busy, s_cpu_rst_n, s_in_ready}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("small_len_no_we", 32'(small_we_cnt), 32'd0);
    applyReset();

    // Random frames: junk before sync, random length and payload, and a
    // checksum byte that is corrupted about half the time.
    for (int n = 0; n < 6; n++) begin
      f.delete();
      junk = int'($urandom_range(0, 2));
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        f.push_back(b);
      end
      len = (n == 0) ? 0 : int'($urandom_range(1, 40));
      f.push_back(8'hA5);
      f.push_back({4'($urandom_range(0, 15)), 4'(len >> 8)});
      f.push_back(8'(len));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        f.push_back(b);
        sum += int'(b);
      end
      b = 8'(256 - (sum % 256));
      if ($urandom_range(0, 1) == 1) b = b + 8'd1;
      f.push_back(b);
      runFrame("rand", f, int'($urandom_range(0, f.size() - 1)));
    end

    // Reset in the middle of DATA drops the load and any further writes.
    pulseStart();
    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'h10, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({12'(i), b});
      applyStimulus(b, 0, 1'b0);
    end
    @(negedge clk);
    arst_n   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    #1;
    checkOutput("midrst_outputs",
                32'({in_ready, pm_we, busy, done, error, err_code, bootstrapping, cpu_rst_n}), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrst_idle", 32'({busy, in_ready, cpu_rst_n}), 32'd0);
    checkOutput("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-memory writer, the producer side of the instruction fetch path.
- Receives a framed byte stream over a valid/ready handshake and writes the payload bytes sequentially into the 12-bit-addressed program memory.
- Verifies a checksum over the payload.
- Holds the CPU in reset and drives bootstrapping while loading; releases the CPU only after a verified load.

Parameters:
ADDR_W, 12, program memory address width (matches the 12-bit PC)
MAX_LEN, 4096, largest accepted payload length in bytes
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 65535, idle cycles allowed between accepted bytes before abort

Ports:
clk  in  1  system clock
arst_n  in  1  reset, synchronous, active-low (sampled on posedge clk only)
start  in  1  single-cycle pulse; begins a load
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte this cycle
pm_we  out  1  program memory write enable
pm_addr  out  ADDR_W  program memory write address
pm_wdata  out  8  program memory write data
bootstrapping  out  1  high while a load is in progress
cpu_rst_n  out  1  active-low CPU hold; low until a load completes
busy  out  1  high in any state other than IDLE, DONE or ERROR
done  out  1  sticky; load verified
error  out  1  sticky; load failed
err_code  out  2  error cause: 01 length, 10 checksum, 11 timeout, 00 none

Behaviour:
- Reset (arst_n low at posedge):
  - State IDLE.
  - All outputs 0, including cpu_rst_n = 0.
  - Internal counters and checksum cleared.
- Handshake: a byte transfers on a posedge where in_valid && in_ready. in_ready is a registered state decode, high only in SYNC, LEN_HI, LEN_LO, DATA and CHECK.
- Transitions:
  - IDLE/DONE/ERROR + start -> SYNC. Entry clears done, error, err_code, byte count, checksum and timeout counter; sets bootstrapping = 1 and cpu_rst_n = 0.
  - start in any other state is ignored.
  - SYNC: accepted byte == SYNC_BYTE -> LEN_HI. Any other byte is discarded and the state stays SYNC (resync).
  - LEN_HI: len[11:8] = in_data[3:0]; in_data[7:4] is ignored -> LEN_LO.
  - LEN_LO: len[7:0] = in_data. Then:
    - len > MAX_LEN -> ERROR, err_code = 01.
    - len == 0 -> CHECK.
    - otherwise -> DATA.
- DATA:
  - On each accepted byte: checksum += in_data (mod 256).
  - On the next cycle: pm_we = 1, pm_addr = current index, pm_wdata = byte. Write latency is 1 cycle; pm_we stays high for one cycle per byte.
  - Index starts at 0 and increments per byte. After byte len-1 -> CHECK.
  - Index never wraps because len <= MAX_LEN.
- CHECK: accept one byte. (checksum + in_data) mod 256 == 0 -> DONE, otherwise -> ERROR with err_code = 10.
- DONE: done = 1, bootstrapping = 0, cpu_rst_n = 1, registered on DONE entry.
- ERROR: error = 1, bootstrapping = 0, cpu_rst_n stays 0. The memory contents are undefined.
- Timeout:
  - The counter resets on every accepted byte and on entry to SYNC.
  - It increments each cycle in SYNC through CHECK when no byte is accepted.
  - Reaching TIMEOUT -> ERROR, err_code = 11.
  - A byte accepted in the same cycle the timeout is reached wins: the counter resets and there is no error.
- Back-pressure: none inside the loader. in_ready is never deasserted mid-frame, and the memory write port is assumed always able to accept writes.
- Reset mid-load: the state returns to IDLE and any pending pm_we is dropped. Memory already written is left as is, and the CPU stays held (cpu_rst_n = 0).
- After DONE, a later start holds the CPU again (cpu_rst_n = 0) for a reload.

Test Plan:
- Nominal load:
  - Stimulus: start, then A5 00 03 11 22 33 9A (sum 0x66 + 0x9A = 0x100).
  - Required response: writes (0,11), (1,22), (2,33); done = 1; cpu_rst_n rises the cycle after CHECK; bootstrapping falls at the same time.
- Bad checksum:
  - Stimulus: same frame with a final byte of 9B.
  - Required response: error = 1, err_code = 10, cpu_rst_n = 0, done = 0.
- Resync and length limit:
  - Stimulus: start, then 00 FF A5 0F FF with MAX_LEN = 4096 (len = 4095).
  - Required response: the leading 00 and FF are discarded; 4095 payload bytes are accepted; the last write lands at address 0xFFE.
  - Stimulus: a separate bench with MAX_LEN = 16 and len = 17.
  - Required response: ERROR, err_code = 01, no pm_we asserted.
- Zero length:
  - Stimulus: A5 00 00 00.
  - Required response: DONE with no pm_we.
- Timeout:
  - Stimulus: TIMEOUT = 8; stall in_valid after LEN_LO.
  - Required response: ERROR, err_code = 11 after exactly 8 idle cycles. A byte arriving on the 8th cycle avoids the error.
- Reset and start rules:
  - Stimulus: assert arst_n low mid-DATA.
  - Required response: next cycle state IDLE, outputs 0, no further pm_we.
  - Stimulus: pulse start while busy.
  - Required response: ignored, frame unaffected.
